// File: rtl/redbus_disk_loader.sv
// Redbus initiator: copies whole 128-byte sectors between the disk drive and RAM, one job per Start.
// All bus strobes are registered one-cycle pulses; read data is sampled two edges after the strobe is set.
module redbus_disk_loader #(
    parameter int POLL_GAP     = 4,
    parameter int POLL_TIMEOUT = 4096
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Dir,
    input  logic [15:0] SectorNum,
    input  logic [7:0]  SectorCount,
    input  logic [15:0] MemBase,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [15:0] RbAddress,
    output logic [7:0]  RbDataOut,
    input  logic [7:0]  RbDataIn,
    output logic        RbRead,
    output logic        RbWrite,
    output logic [15:0] MemAddress,
    output logic [7:0]  MemWData,
    input  logic [7:0]  MemRData,
    output logic        MemRead,
    output logic        MemWrite
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int PW = $clog2(POLL_TIMEOUT + 1);

    localparam logic [15:0] REG_SEC_LO = 16'h0080;
    localparam logic [15:0] REG_SEC_HI = 16'h0081;
    localparam logic [15:0] REG_CMD    = 16'h0082;

    typedef enum logic [3:0] {
        IDLE, SEC_LO, SEC_HI, FILL, FILL_END, CMD, WAIT,
        POLL, POLL_CHK, DRAIN, NEXT, FINISH
    } state_t;

    state_t        state;
    logic          dirLat;
    logic [15:0]   curSec;
    logic [15:0]   curMem;
    logic [7:0]    remaining;
    logic [6:0]    byteIdx;
    logic          phaseB;
    logic [GW-1:0] gapCnt;
    logic [PW-1:0] pollCnt;

    logic [6:0]  nextIdx;
    logic [15:0] memAddrK;
    logic [15:0] memAddrNext;
    logic [15:0] secNext;
    logic [7:0]  cmdByte;

    assign nextIdx     = byteIdx + 7'd1;
    assign memAddrK    = curMem + {9'd0, byteIdx};
    assign memAddrNext = curMem + {9'd0, nextIdx};
    assign secNext     = curSec + 16'd1;
    assign cmdByte     = {7'b0000010, dirLat};

    // Each state's entry edge also loads the strobes for the action it performs,
    // so the state register and bus outputs always describe the same cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            dirLat     <= 1'b0;
            curSec     <= '0;
            curMem     <= '0;
            remaining  <= '0;
            byteIdx    <= '0;
            phaseB     <= 1'b0;
            gapCnt     <= '0;
            pollCnt    <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
            RbAddress  <= '0;
            RbDataOut  <= '0;
            RbRead     <= 1'b0;
            RbWrite    <= 1'b0;
            MemAddress <= '0;
            MemWData   <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
        end else begin
            RbRead   <= 1'b0;
            RbWrite  <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            Done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        Error     <= 1'b0;
                        dirLat    <= Dir;
                        curSec    <= SectorNum;
                        curMem    <= MemBase;
                        remaining <= SectorCount;
                        if (SectorCount == 8'd0) begin
                            Done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            Busy      <= 1'b1;
                            state     <= SEC_LO;
                            RbWrite   <= 1'b1;
                            RbAddress <= REG_SEC_LO;
                            RbDataOut <= SectorNum[7:0];
                        end
                    end
                end
                SEC_LO: begin
                    state     <= SEC_HI;
                    RbWrite   <= 1'b1;
                    RbAddress <= REG_SEC_HI;
                    RbDataOut <= curSec[15:8];
                end
                SEC_HI: begin
                    byteIdx <= '0;
                    phaseB  <= 1'b0;
                    if (dirLat) begin
                        state      <= FILL;
                        MemRead    <= 1'b1;
                        MemAddress <= curMem;
                    end else begin
                        state     <= CMD;
                        pollCnt   <= '0;
                        RbWrite   <= 1'b1;
                        RbAddress <= REG_CMD;
                        RbDataOut <= cmdByte;
                    end
                end
                FILL: begin
                    if (!phaseB) begin
                        phaseB <= 1'b1;
                    end else begin
                        // RAM data for byte k is valid now; its drive write overlaps the next RAM read.
                        phaseB    <= 1'b0;
                        byteIdx   <= nextIdx;
                        RbWrite   <= 1'b1;
                        RbAddress <= {9'd0, byteIdx};
                        RbDataOut <= MemRData;
                        if (byteIdx == 7'd127) begin
                            state <= FILL_END;
                        end else begin
                            MemRead    <= 1'b1;
                            MemAddress <= memAddrNext;
                        end
                    end
                end
                FILL_END: begin
                    state     <= CMD;
                    pollCnt   <= '0;
                    RbWrite   <= 1'b1;
                    RbAddress <= REG_CMD;
                    RbDataOut <= cmdByte;
                end
                CMD: begin
                    state  <= WAIT;
                    gapCnt <= '0;
                end
                WAIT: begin
                    if (gapCnt == GW'(POLL_GAP - 1)) begin
                        state     <= POLL;
                        RbRead    <= 1'b1;
                        RbAddress <= REG_CMD;
                    end else begin
                        gapCnt <= gapCnt + GW'(1);
                    end
                end
                POLL: begin
                    state <= POLL_CHK;
                end
                POLL_CHK: begin
                    if (RbDataIn == 8'h00) begin
                        if (dirLat) begin
                            state <= NEXT;
                        end else begin
                            state     <= DRAIN;
                            byteIdx   <= '0;
                            phaseB    <= 1'b0;
                            RbRead    <= 1'b1;
                            RbAddress <= 16'h0000;
                        end
                    end else if (RbDataIn == 8'hFF || pollCnt == PW'(POLL_TIMEOUT - 1)) begin
                        Error <= 1'b1;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        pollCnt <= pollCnt + PW'(1);
                        gapCnt  <= '0;
                        state   <= WAIT;
                    end
                end
                DRAIN: begin
                    if (!phaseB) begin
                        phaseB <= 1'b1;
                    end else begin
                        phaseB     <= 1'b0;
                        byteIdx    <= nextIdx;
                        MemWrite   <= 1'b1;
                        MemAddress <= memAddrK;
                        MemWData   <= RbDataIn;
                        if (byteIdx == 7'd127) begin
                            state <= NEXT;
                        end else begin
                            RbRead    <= 1'b1;
                            RbAddress <= {9'd0, nextIdx};
                        end
                    end
                end
                NEXT: begin
                    curSec    <= secNext;
                    curMem    <= curMem + 16'd128;
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        state     <= SEC_LO;
                        RbWrite   <= 1'b1;
                        RbAddress <= REG_SEC_LO;
                        RbDataOut <= secNext[7:0];
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redbus_disk_loader.sv
// Scoreboarded bench: a drive model and a RAM model answer the DUT; expected bus events come from a job-level model.
module tb_redbus_disk_loader;

    localparam int TIMEOUT = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Dir = 1'b0;
    logic [15:0] SectorNum = '0;
    logic [7:0]  SectorCount = '0;
    logic [15:0] MemBase = '0;
    logic        Busy, Done, Error;
    logic [15:0] RbAddress;
    logic [7:0]  RbDataOut;
    logic [7:0]  RbDataIn = '0;
    logic        RbRead, RbWrite;
    logic [15:0] MemAddress;
    logic [7:0]  MemWData;
    logic [7:0]  MemRData = '0;
    logic        MemRead, MemWrite;

    redbus_disk_loader #(.POLL_GAP(4), .POLL_TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Dir(Dir),
        .SectorNum(SectorNum), .SectorCount(SectorCount), .MemBase(MemBase),
        .Busy(Busy), .Done(Done), .Error(Error),
        .RbAddress(RbAddress), .RbDataOut(RbDataOut), .RbDataIn(RbDataIn),
        .RbRead(RbRead), .RbWrite(RbWrite),
        .MemAddress(MemAddress), .MemWData(MemWData), .MemRData(MemRData),
        .MemRead(MemRead), .MemWrite(MemWrite)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram [0:65535];
    logic [7:0]  drvBuf [0:127];
    logic [15:0] secReg = '0;
    logic [7:0]  cmdReg = '0;
    logic [7:0]  finalSt = '0;
    int          pollsLeft = 0;
    int          sIdx = 0;
    int          pollReads = 0;
    int          sBase = 0;
    int          stBusy [0:7];
    logic [7:0]  stFinal [0:7];
    bit          patSec = 1'b0;
    bit          fillReq = 1'b0;

    logic [23:0] rbQ [$];
    logic [23:0] memQ [$];
    bit          doneQ [$];

    function automatic logic [7:0] pat(input logic [15:0] sec, input int k);
        logic [7:0] kk;
        kk = 8'(k);
        return kk ^ 8'h5A ^ (patSec ? sec[7:0] : 8'h00);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Disk drive: sector buffer, sector registers, command register with scripted status.
    always @(posedge Clock) begin
        if (RbWrite) begin
            if (RbAddress < 16'h0080) drvBuf[RbAddress[6:0]] <= RbDataOut;
            else if (RbAddress == 16'h0080) secReg[7:0] <= RbDataOut;
            else if (RbAddress == 16'h0081) secReg[15:8] <= RbDataOut;
            else if (RbAddress == 16'h0082) begin
                cmdReg    <= RbDataOut;
                pollsLeft <= stBusy[(sIdx - sBase) % 8];
                finalSt   <= stFinal[(sIdx - sBase) % 8];
                sIdx      <= sIdx + 1;
                if (RbDataOut == 8'd4)
                    for (int k = 0; k < 128; k++) drvBuf[k] <= pat(secReg, k);
            end
        end
        if (RbRead) begin
            if (RbAddress == 16'h0082) begin
                pollReads <= pollReads + 1;
                if (pollsLeft > 0) begin
                    RbDataIn  <= cmdReg;
                    pollsLeft <= pollsLeft - 1;
                end else begin
                    RbDataIn <= finalSt;
                end
            end else begin
                RbDataIn <= drvBuf[RbAddress[6:0]];
            end
        end
    end

    always @(posedge Clock) begin
        if (fillReq)
            for (int i = 0; i < 65536; i++) ram[i] <= 8'($urandom);
        if (MemRead) MemRData <= ram[MemAddress];
        if (MemWrite) ram[MemAddress] <= MemWData;
    end

    // Monitor: every strobe the DUT presents is matched against the scoreboard.
    logic [23:0] ev;
    always @(negedge Clock) begin
        if (!Reset) begin
            if (RbWrite) begin
                if (rbQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rb_write_unexpected: got addr %h data %h, required no write", RbAddress, RbDataOut);
                end else begin
                    ev = rbQ.pop_front();
                    chk("rb_write", {8'h00, RbAddress, RbDataOut}, {8'h00, ev});
                end
            end
            if (MemWrite) begin
                if (memQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_write_unexpected: got addr %h data %h, required no write", MemAddress, MemWData);
                end else begin
                    ev = memQ.pop_front();
                    chk("mem_write", {8'h00, MemAddress, MemWData}, {8'h00, ev});
                end
            end
            if (Done) begin
                if (doneQ.size() == 0) chk("done_unexpected", 32'(Done), 32'd0);
                else chk("done_error_flag", 32'(Error), 32'(doneQ.pop_front()));
            end
            if ((RbRead && RbWrite) || (MemRead && MemWrite))
                chk("strobe_exclusive", {28'd0, RbRead, RbWrite, MemRead, MemWrite}, 32'd0);
        end
    end

    // Job-level reference: sector by sector, what must appear on each bus and how many polls it takes.
    task automatic model(input bit d, input logic [15:0] sec, input logic [7:0] cnt,
                         input logic [15:0] base, output int expPolls, output bit err);
        logic [15:0] secN, mem, a;
        expPolls = 0;
        err = 1'b0;
        for (int s = 0; s < int'(cnt); s++) begin
            secN = sec + 16'(s);
            mem  = base + 16'(s * 128);
            rbQ.push_back({16'h0080, secN[7:0]});
            rbQ.push_back({16'h0081, secN[15:8]});
            if (d) for (int k = 0; k < 128; k++) begin
                a = mem + 16'(k);
                rbQ.push_back({16'(k), ram[a]});
            end
            rbQ.push_back({16'h0082, d ? 8'd5 : 8'd4});
            if (stBusy[s] >= TIMEOUT) begin
                expPolls += TIMEOUT; err = 1'b1; break;
            end
            expPolls += stBusy[s] + 1;
            if (stFinal[s] == 8'hFF) begin
                err = 1'b1; break;
            end
            if (!d) for (int k = 0; k < 128; k++) begin
                a = mem + 16'(k);
                memQ.push_back({a, pat(secN, k)});
            end
        end
        doneQ.push_back(err);
    endtask

    task automatic startJob(input bit d, input logic [15:0] sec, input logic [7:0] cnt, input logic [15:0] base);
        sBase = sIdx;
        @(negedge Clock);
        Dir = d; SectorNum = sec; SectorCount = cnt; MemBase = base; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic runJob(input string name, input bit d, input logic [15:0] sec, input logic [7:0] cnt,
                          input logic [15:0] base, input bit poke);
        int expPolls, p0, n;
        bit err;
        model(d, sec, cnt, base, expPolls, err);
        p0 = pollReads;
        startJob(d, sec, cnt, base);
        chk({name, "_busy"}, 32'(Busy), 32'd1);
        if (poke) begin
            repeat (10) @(negedge Clock);
            Dir = ~d; SectorCount = 8'd0; Start = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
            chk({name, "_busy_after_ignored_start"}, 32'(Busy), 32'd1);
        end
        n = 0;
        while (!Done && n < 20000) begin
            @(negedge Clock);
            n++;
        end
        chk({name, "_done_seen"}, 32'(Done), 32'd1);
        repeat (3) @(negedge Clock);
        chk({name, "_rb_left"}, 32'(rbQ.size()), 32'd0);
        chk({name, "_mem_left"}, 32'(memQ.size()), 32'd0);
        chk({name, "_done_left"}, 32'(doneQ.size()), 32'd0);
        chk({name, "_polls"}, 32'(pollReads - p0), 32'(expPolls));
        chk({name, "_error"}, 32'(Error), 32'(err));
        chk({name, "_busy_end"}, 32'(Busy), 32'd0);
        rbQ.delete(); memQ.delete(); doneQ.delete();
    endtask

    task automatic clearStatus();
        for (int i = 0; i < 8; i++) begin
            stBusy[i] = 0;
            stFinal[i] = 8'h00;
        end
    endtask

    initial begin
        int expPolls, n;
        bit err;
        clearStatus();
        fillReq = 1'b1;
        @(negedge Clock);
        fillReq = 1'b0;
        @(negedge Clock);
        chk("reset_outputs",
            {6'd0, Busy, Done, Error, RbRead, RbWrite, MemRead, MemWrite, RbAddress, RbDataOut[0]},
            32'd0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // Single sector disk->RAM, status clears on the third poll.
        patSec = 1'b0;
        stBusy[0] = 2;
        runJob("t1", 1'b0, 16'h0012, 8'd1, 16'h0400, 1'b0);
        for (int i = 0; i < 128; i++) begin
            logic [7:0] ii;
            ii = 8'(i);
            chk("t1_ram", 32'(ram[16'h0400 + 16'(i)]), 32'(ii ^ 8'h5A));
        end

        // RAM->disk with sector and address wrap; a stray Start mid-job must be ignored.
        patSec = 1'b1;
        clearStatus();
        stBusy[0] = 1;
        runJob("t2", 1'b1, 16'hFFFF, 8'd2, 16'hFF80, 1'b1);

        // Status 0xFF on the first poll of sector 2 of 3.
        clearStatus();
        stFinal[1] = 8'hFF;
        runJob("t3", 1'b0, 16'h0300, 8'd3, 16'h2000, 1'b0);

        // Drive never clears the command register.
        clearStatus();
        stBusy[0] = 255;
        runJob("t4", 1'b1, 16'h0042, 8'd2, 16'h1000, 1'b0);

        // Zero-length job.
        doneQ.push_back(1'b0);
        startJob(1'b0, 16'h0001, 8'd0, 16'h0000);
        chk("t5_done_next", 32'(Done), 32'd1);
        chk("t5_busy_low", 32'(Busy), 32'd0);
        repeat (3) @(negedge Clock);
        chk("t5_done_left", 32'(doneQ.size()), 32'd0);
        chk("t5_error", 32'(Error), 32'd0);

        // Reset in the middle of the first sector drain.
        clearStatus();
        model(1'b0, 16'h0700, 8'd2, 16'h3000, expPolls, err);
        startJob(1'b0, 16'h0700, 8'd2, 16'h3000);
        n = 0;
        while (memQ.size() > 200 && n < 5000) begin
            @(negedge Clock);
            n++;
        end
        chk("t6_reached_drain", 32'(memQ.size() <= 200), 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        chk("t6_strobes_after_reset",
            {26'd0, RbRead, RbWrite, MemRead, MemWrite, Done, Busy}, 32'd0);
        @(negedge Clock);
        rbQ.delete(); memQ.delete(); doneQ.delete();
        Reset = 1'b0;
        repeat (30) @(negedge Clock);
        chk("t6_idle_after_reset", {30'd0, Busy, Error}, 32'd0);
        runJob("t6_fresh", 1'b0, 16'h0900, 8'd1, 16'h5000, 1'b0);

        // Randomised jobs.
        for (int j = 0; j < 5; j++) begin
            clearStatus();
            for (int i = 0; i < 8; i++) stBusy[i] = int'($urandom_range(0, 3));
            runJob("rand", 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom_range(1, 3)),
                   16'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
